// File: rtl/seq_divider_if.sv
// Handshake and operand/result bundle for the sequential divider.
// The divider uses the slave modport; the requester uses master.
interface seq_divider_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider producing one quotient bit per clock.
// Results stay in registers until the next accepted start.
module seq_divider #(
  parameter int WIDTH = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  seq_divider_if.slave   bus
);
  localparam int            CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(32'd1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH:0]   r_q, r_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH:0]   rs_s;
  logic [WIDTH:0]   t_s;

  // Trial subtraction: the top bit of t_s is the borrow.
  assign rs_s = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
  assign t_s  = rs_s - {1'b0, dvsr_q};

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      q_q     <= {WIDTH{1'b0}};
      r_q     <= {(WIDTH+1){1'b0}};
      cnt_q   <= {CW{1'b0}};
      dvsr_q  <= {WIDTH{1'b0}};
      quot_q  <= {WIDTH{1'b0}};
      rem_q   <= {WIDTH{1'b0}};
      dbz_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      dvsr_q  <= dvsr_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    dvsr_d  = dvsr_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.divisor != {WIDTH{1'b0}}) begin
            q_d     = bus.dividend;
            r_d     = {(WIDTH+1){1'b0}};
            cnt_d   = {CW{1'b0}};
            dvsr_d  = bus.divisor;
            busy_d  = 1'b1;
            state_d = S_CALC;
          end else begin
            quot_d  = {WIDTH{1'b1}};
            rem_d   = bus.dividend;
            dbz_d   = 1'b1;
            done_d  = 1'b1;
            state_d = S_DONE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        if (!t_s[WIDTH]) begin
          r_d = t_s;
          q_d = {q_q[WIDTH-2:0], 1'b1};
        end else begin
          r_d = rs_s;
          q_d = {q_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + CNT_ONE;
        // Last iteration publishes the freshly computed Q/R directly.
        if (cnt_q == CNT_LAST) begin
          quot_d  = q_d;
          rem_d   = r_d[WIDTH-1:0];
          dbz_d   = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_CALC;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.quotient    = quot_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_divider.sv
// Directed and exhaustive checks of seq_divider at WIDTH=4: latency, handshake,
// divide-by-zero, ignored starts and asynchronous reset mid-operation.
module tb_seq_divider;
  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  seq_divider_if #(.WIDTH(4)) dif ();

  seq_divider #(.WIDTH(4)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (dif.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] dvd;
    logic [3:0] dvs;
    logic [3:0] eq;
    logic [3:0] er;
    logic       ez;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Called right after a negedge with the DUT in IDLE; returns after 8 more negedges.
  task automatic run_op(input logic [3:0] dvd, input logic [3:0] dvs,
                        input logic [3:0] eq, input logic [3:0] er,
                        input logic ez, input bit noise, input string tag);
    int busy_cnt = 0;
    int done_cnt = 0;
    int done_idx = -1;
    int hold_err = 0;
    int q_at_done = -1;
    int r_at_done = -1;
    int z_at_done = -1;
    logic [3:0] prev_q = dif.quotient;
    logic [3:0] prev_r = dif.remainder;
    dif.dividend = dvd;
    dif.divisor  = dvs;
    dif.start    = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (dif.busy) begin
        busy_cnt++;
        if (dif.quotient != prev_q || dif.remainder != prev_r) hold_err++;
      end
      if (dif.done) begin
        done_cnt++;
        if (done_idx < 0) begin
          done_idx  = k;
          q_at_done = int'(dif.quotient);
          r_at_done = int'(dif.remainder);
          z_at_done = int'(dif.div_by_zero);
        end
      end
      dif.start = noise && (k <= 5);
      if (noise) begin
        dif.dividend = 4'b1111;
        dif.divisor  = 4'b0001;
      end
    end
    chk({tag, " done_count"}, done_cnt, 1);
    chk({tag, " done_latency"}, done_idx, ez ? 1 : 5);
    chk({tag, " busy_cycles"}, busy_cnt, ez ? 0 : 4);
    chk({tag, " hold_while_busy"}, hold_err, 0);
    chk({tag, " result_at_done"}, (q_at_done << 5) | (r_at_done << 1) | z_at_done,
        (int'(eq) << 5) | (int'(er) << 1) | int'(ez));
    chk({tag, " quotient"}, int'(dif.quotient), int'(eq));
    chk({tag, " remainder"}, int'(dif.remainder), int'(er));
    chk({tag, " div_by_zero"}, int'(dif.div_by_zero), int'(ez));
  endtask

  initial begin
    vecs[0] = '{4'b1001, 4'b0010, 4'b0100, 4'b0001, 1'b0};
    vecs[1] = '{4'b1111, 4'b1111, 4'b0001, 4'b0000, 1'b0};
    vecs[2] = '{4'b1000, 4'b1001, 4'b0000, 4'b1000, 1'b0};
    vecs[3] = '{4'b1010, 4'b0110, 4'b0001, 4'b0100, 1'b0};
    vecs[4] = '{4'b0110, 4'b0000, 4'b1111, 4'b0110, 1'b1};
    vecs[5] = '{4'b0110, 4'b0011, 4'b0010, 4'b0000, 1'b0};

    // Reset held with start asserted.
    rst_n        = 1'b0;
    dif.start    = 1'b1;
    dif.dividend = 4'b1001;
    dif.divisor  = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("reset_outputs", {dif.busy, dif.done, dif.quotient, dif.remainder, dif.div_by_zero},
          0);
    end
    dif.start = 1'b0;
    rst_n     = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("idle_after_reset", {dif.busy, dif.done, dif.quotient, dif.remainder, dif.div_by_zero},
          0);
    end

    foreach (vecs[i])
      run_op(vecs[i].dvd, vecs[i].dvs, vecs[i].eq, vecs[i].er, vecs[i].ez, 1'b0,
             $sformatf("vec%0d", i));

    // Starts presented during CALC and DONE must be ignored.
    run_op(4'b1001, 4'b0010, 4'b0100, 4'b0001, 1'b0, 1'b1, "ignored_start");
    repeat (3) @(negedge clk);
    chk("hold_after_done", {dif.quotient, dif.remainder, dif.busy, dif.done}, 8'b0100_0001 << 2);

    // Asynchronous reset two cycles into CALC.
    dif.dividend = 4'b1111;
    dif.divisor  = 4'b0010;
    dif.start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    dif.start = 1'b0;
    chk("midop_busy", int'(dif.busy), 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("midop_reset_clears",
           {dif.busy, dif.done, dif.quotient, dif.remainder, dif.div_by_zero}, 0);
    begin
      int done_seen = 0;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        done_seen += int'(dif.done) + int'(dif.busy);
      end
      chk("midop_no_done", done_seen, 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    run_op(4'b1111, 4'b0010, 4'b0111, 4'b0001, 1'b0, 1'b0, "after_reset");

    // Exhaustive sweep of all operand pairs.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        logic [3:0] eq;
        logic [3:0] er;
        if (b == 0) begin
          eq = 4'b1111;
          er = 4'(a);
        end else begin
          eq = 4'(a / b);
          er = 4'(a % b);
        end
        run_op(4'(a), 4'(b), eq, er, b == 0, 1'b0, $sformatf("sweep_%0d_%0d", a, b));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Multi-cycle unsigned restoring divider, one quotient bit per clock.
- Sits directly downstream of the 4-bit binary subtractor. Each iteration computes one trial subtraction (partial remainder minus divisor) and uses the borrow to decide the quotient bit.
- Operands come in through a start/busy/done handshake. Results are held in registers until the next accepted start.

Parameters:
- WIDTH, 4, operand/result width in bits (minimum 2).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- dividend  input  WIDTH  unsigned dividend; captured on the accepting edge
- divisor  input  WIDTH  unsigned divisor; captured on the accepting edge
- busy  output  1  high while in CALC
- done  output  1  single-cycle pulse; results valid from this cycle on
- quotient  output  WIDTH  registered quotient
- remainder  output  WIDTH  registered remainder
- div_by_zero  output  1  registered flag; set with done when divisor was 0

Behaviour:
- Clock and reset:
  - Single clock domain. Reset is asynchronous and active-low, named rst_n. Clock is clk.
  - Reset values: state=IDLE; busy=0, done=0, quotient=0, remainder=0, div_by_zero=0; internal counter and shift registers = 0.
  - rst_n low mid-operation aborts immediately; no done is produced for the aborted operation.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - On an edge with start=1 and divisor!=0: capture operands. Q shift reg = dividend, partial remainder R (WIDTH+1 bits) = 0, count = 0. Go to CALC; busy=1.
  - On an edge with start=1 and divisor==0: go to DONE; done=1, div_by_zero=1, quotient = all ones, remainder = dividend.
- CALC, one iteration per edge:
  - Rs = {R[WIDTH-1:0], Q[WIDTH-1]}.
  - T = Rs - {1'b0, divisor}, computed in WIDTH+1 bits.
  - If T[WIDTH]==0 (no borrow): R=T and Q={Q[WIDTH-2:0],1}. Otherwise: R=Rs and Q={Q[WIDTH-2:0],0}.
  - count increments each iteration.
  - The edge that completes iteration WIDTH writes quotient = final Q and remainder = R[WIDTH-1:0], clears div_by_zero, and sets busy=0, done=1, state=DONE.
- DONE:
  - Lasts exactly one cycle. The next edge sets done=0 and state=IDLE.
  - start is ignored in DONE.
- Latency:
  - start accepted at edge E0.
  - Normal case: done is high for the cycle after edge E0+WIDTH (4 cycles for WIDTH=4). busy is high for exactly WIDTH cycles.
  - Divide-by-zero: done is high for the cycle after E0 and busy never rises.
- start while busy or in DONE is ignored. No queuing; the operand inputs are don't-care then.
- quotient, remainder and div_by_zero hold their previous values throughout CALC. They change only on the completion edge or on reset.
- Back-to-back throughput: a new start is accepted at the earliest one cycle after done falls (i.e. in IDLE).
- Arithmetic is unsigned. Invariant on normal completion: dividend = quotient*divisor + remainder, with remainder < divisor.

Test Plan:
- Reset: assert rst_n=0 with start=1 -> busy=0, done=0, quotient=0000, remainder=0000, div_by_zero=0. These hold until the first accepted start after release.
- Directed vectors, each checking that done pulses exactly once, 4 cycles after the accepting edge, and that busy is high for 4 cycles:
  - 1001/0010 -> quotient=0100, remainder=0001
  - 1111/1111 -> quotient=0001, remainder=0000
  - 1000/1001 -> quotient=0000, remainder=1000
  - 1010/0110 -> quotient=0001, remainder=0100
- Divide-by-zero: 0110/0000 -> done on the next cycle, div_by_zero=1, quotient=1111, remainder=0110, busy stays 0. A following 0110/0011 -> quotient=0010, remainder=0000, div_by_zero=0.
- Ignored start: start 1001/0010, then pulse start with 1111/0001 during CALC and during the DONE cycle -> only one done; result 0100/0001; outputs hold 0100/0001 until the next accepted start.
- Reset mid-operation: start 1111/0010, drop rst_n after 2 cycles of CALC -> busy=0 and outputs=0 immediately; no done. After release, 1111/0010 -> quotient=0111, remainder=0001.
- Exhaustive WIDTH=4 sweep: all 256 dividend/divisor pairs issued back-to-back -> each result matches / and %. Divisor 0 matches the divide-by-zero rule. quotient/remainder never change while busy=1.
